// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit sequencer: event kind, the buffered
// event record and a lane popcount helper.
package difftest_pkg;

    // Events are stored at this fixed width; the top zero-extends narrower
    // XLEN values on the way in and truncates on the way out (XLEN <= 64).
    localparam int MAX_XLEN = 64;

    typedef enum logic {
        EVT_COMMIT = 1'b0,
        EVT_TRAP   = 1'b1
    } evt_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } out_state_e;

    typedef struct packed {
        evt_kind_e             kind;
        logic [MAX_XLEN-1:0]   pc;
        logic [31:0]           insn;
        logic                  wen;
        logic [4:0]            waddr;
        logic [MAX_XLEN-1:0]   wdata;
    } evt_t;

    // Number of set bits in a commit_valid vector (at most 4 lanes).
    function automatic logic [2:0] popcount(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/difftest_evt_fifo.sv
// Multi-push / single-pop circular buffer of evt_t. Up to PUSH_W entries
// are written at consecutive tail slots per cycle; the caller guarantees
// there is room for push_cnt entries. The head entry is read combinationally.
module difftest_evt_fifo
    import difftest_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PUSH_W = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2:0]               push_cnt,
    input  evt_t [PUSH_W-1:0]        push_data,
    input  logic                     pop,
    output evt_t                     head,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);

    evt_t           mem [DEPTH];
    logic [AW-1:0]  head_ptr;
    logic [AW-1:0]  tail_ptr;

    // Pointers and fill level; power-of-two DEPTH makes wrap a truncation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            occupancy <= '0;
        end else begin
            tail_ptr  <= tail_ptr + AW'(push_cnt);
            if (pop) head_ptr <= head_ptr + AW'(1);
            occupancy <= occupancy + (AW+1)'(push_cnt) - (AW+1)'(pop);
        end
    end

    // Write the first push_cnt compacted entries starting at the tail.
    always_ff @(posedge clock) begin
        for (int i = 0; i < PUSH_W; i++) begin
            if (3'(i) < push_cnt) mem[tail_ptr + AW'(i)] <= push_data[i];
        end
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/difftest_commit_sequencer.sv
// Serialises multi-lane retire events (plus one trap per cycle) into an
// in-order one-event-per-cycle stream for the co-simulation checker.
// Optional watchdog: define DIFFTEST_WATCHDOG_EN to add WDOG_LIMIT and a
// sticky timeout output that halts the stream after a long push-free gap.
module difftest_commit_sequencer
    import difftest_pkg::*;
#(
    parameter int COMMITS = 2,
    parameter int DEPTH   = 16,
    parameter int XLEN    = 64
`ifdef DIFFTEST_WATCHDOG_EN
    , parameter int WDOG_LIMIT = 100000
`endif
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COMMITS-1:0]         commit_valid,
    input  logic [COMMITS*XLEN-1:0]    commit_pc,
    input  logic [COMMITS*32-1:0]      commit_insn,
    input  logic [COMMITS-1:0]         commit_wen,
    input  logic [COMMITS*5-1:0]       commit_waddr,
    input  logic [COMMITS*XLEN-1:0]    commit_wdata,
    input  logic                       trap_valid,
    input  logic [XLEN-1:0]            trap_cause,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_kind,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_insn,
    output logic                       out_wen,
    output logic [4:0]                 out_waddr,
    output logic [XLEN-1:0]            out_wdata,
    input  logic                       chk_mismatch,
    output logic                       fail,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef DIFFTEST_WATCHDOG_EN
    , output logic                     timeout
`endif
);
    localparam int OW     = $clog2(DEPTH) + 1;
    localparam int PUSH_W = COMMITS + 1;

    evt_t [PUSH_W-1:0] slots;
    evt_t              head;
    logic [2:0]        n_in;
    logic [2:0]        push_cnt;
    logic              push_ok;
    logic              pop;
    logic              halt_wdog;
    logic [OW-1:0]     occ_next;
    out_state_e        st, st_next;

    // Compact valid lanes in ascending order, trap last.
    always_comb begin
        int idx;
        slots = '0;
        idx   = 0;
        for (int i = 0; i < COMMITS; i++) begin
            if (commit_valid[i]) begin
                slots[idx].kind  = EVT_COMMIT;
                slots[idx].pc    = MAX_XLEN'(commit_pc[i*XLEN +: XLEN]);
                slots[idx].insn  = commit_insn[i*32 +: 32];
                slots[idx].wen   = commit_wen[i];
                slots[idx].waddr = commit_waddr[i*5 +: 5];
                slots[idx].wdata = MAX_XLEN'(commit_wdata[i*XLEN +: XLEN]);
                idx = idx + 1;
            end
        end
        if (trap_valid) begin
            slots[idx].kind  = EVT_TRAP;
            slots[idx].pc    = '0;
            slots[idx].insn  = '0;
            slots[idx].wen   = 1'b0;
            slots[idx].waddr = '0;
            slots[idx].wdata = MAX_XLEN'(trap_cause);
        end
    end

    // A cycle is accepted all-or-nothing against registered occupancy only.
    assign n_in     = popcount(4'(commit_valid)) + {2'b00, trap_valid};
    assign in_ready = (OW'(DEPTH) - occupancy) >= OW'(PUSH_W);
    assign push_ok  = in_ready && (n_in != 3'd0);
    assign push_cnt = push_ok ? n_in : 3'd0;
    assign pop      = out_valid && out_ready;
    assign occ_next = occupancy + OW'(push_cnt) - OW'(pop);

    difftest_evt_fifo #(
        .DEPTH  (DEPTH),
        .PUSH_W (PUSH_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_cnt  (push_cnt),
        .push_data (slots),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy)
    );

    // Output state register.
    always_ff @(posedge clock) begin
        if (!reset) st <= ST_IDLE;
        else        st <= st_next;
    end

    // HALT is terminal until reset; otherwise track buffer emptiness.
    always_comb begin
        st_next = st;
        if (st == ST_HALT)              st_next = ST_HALT;
        else if (pop && chk_mismatch)   st_next = ST_HALT;
        else if (occ_next != '0)        st_next = ST_DRAIN;
        else                            st_next = ST_IDLE;
    end

    // Drive handshake and event fields straight from the head entry.
    always_comb begin
        out_valid = (st == ST_DRAIN) && !halt_wdog;
        fail      = (st == ST_HALT);
        out_kind  = head.kind;
        out_pc    = XLEN'(head.pc);
        out_insn  = head.insn;
        out_waddr = head.waddr;
        out_wen   = head.wen && (head.waddr != 5'd0);
        out_wdata = XLEN'(head.wdata);
    end

    // Sticky record of any input cycle refused for lack of space.
    always_ff @(posedge clock) begin
        if (!reset)                              overflow <= 1'b0;
        else if ((n_in != 3'd0) && !in_ready)    overflow <= 1'b1;
    end

`ifdef DIFFTEST_WATCHDOG_EN
    logic [31:0] wdog_cnt;

    // Count push-free cycles; latch timeout once the limit is reached.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (push_ok)                             wdog_cnt <= '0;
            else if (wdog_cnt != 32'(WDOG_LIMIT))    wdog_cnt <= wdog_cnt + 32'd1;
            if (wdog_cnt == 32'(WDOG_LIMIT))         timeout  <= 1'b1;
        end
    end

    assign halt_wdog = timeout;
`else
    assign halt_wdog = 1'b0;
`endif

endmodule

// File: tb/tb_difftest_commit_sequencer.sv
// Bench for difftest_commit_sequencer (COMMITS=2, DEPTH=16, XLEN=64):
// a vector table plus hand-written backpressure / mismatch / reset / full
// sequences, with an expected-event scoreboard queue.
module tb_difftest_commit_sequencer;
    localparam int COMMITS = 2;
    localparam int DEPTH   = 16;
    localparam int XLEN    = 64;

    logic                     clock;
    logic                     reset;
    logic [COMMITS-1:0]       commit_valid;
    logic [COMMITS*XLEN-1:0]  commit_pc;
    logic [COMMITS*32-1:0]    commit_insn;
    logic [COMMITS-1:0]       commit_wen;
    logic [COMMITS*5-1:0]     commit_waddr;
    logic [COMMITS*XLEN-1:0]  commit_wdata;
    logic                     trap_valid;
    logic [XLEN-1:0]          trap_cause;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_kind;
    logic [XLEN-1:0]          out_pc;
    logic [31:0]              out_insn;
    logic                     out_wen;
    logic [4:0]               out_waddr;
    logic [XLEN-1:0]          out_wdata;
    logic                     chk_mismatch;
    logic                     fail;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   occupancy;

    difftest_commit_sequencer #(
        .COMMITS (COMMITS),
        .DEPTH   (DEPTH),
        .XLEN    (XLEN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_insn  (commit_insn),
        .commit_wen   (commit_wen),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_pc       (out_pc),
        .out_insn     (out_insn),
        .out_wen      (out_wen),
        .out_waddr    (out_waddr),
        .out_wdata    (out_wdata),
        .chk_mismatch (chk_mismatch),
        .fail         (fail),
        .overflow     (overflow),
        .occupancy    (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        kind;
        logic [63:0] pc;
        logic [31:0] insn;
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
    } exp_t;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic        wen0;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic        trap;
        logic [63:0] cause;
        int          occ;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mocc   = 0;
    bit   movf   = 0;
    bit   mfail  = 0;
    int   pops   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Lane 1 always writes x5; insn is derived from the pc so it is checkable.
    task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                         input logic wen0, input logic [4:0] wa0, input logic [63:0] wd0,
                         input logic trap, input logic [63:0] cause);
        commit_valid = v;
        commit_pc    = {pc1, pc0};
        commit_insn  = {pc1[31:0] ^ 32'h13, pc0[31:0] ^ 32'h13};
        commit_wen   = {1'b1, wen0};
        commit_waddr = {5'd5, wa0};
        commit_wdata = {pc1 ^ 64'h55, wd0};
        trap_valid   = trap;
        trap_cause   = cause;
    endtask

    task automatic idle();
        drive(2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0);
    endtask

    // One clock: check the handshake against the scoreboard, update the
    // expected state from the driven inputs, then check registered outputs.
    task automatic step();
        exp_t e;
        int   n;
        int   occ_old;
        bit   exp_v;
        if (!reset) begin
            @(posedge clock); #1;
            sb.delete(); mocc = 0; movf = 0; mfail = 0; pops = 0;
            return;
        end
        occ_old = mocc;
        exp_v   = (mocc > 0) && !mfail;
        chk("out_valid", out_valid, exp_v);
        chk("in_ready", in_ready, (DEPTH - occ_old) >= COMMITS + 1);
        if (exp_v && out_ready) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow actual=pop expected=no_event");
            end else begin
                e = sb.pop_front();
                chk("out_kind", out_kind, e.kind);
                chk("out_pc", out_pc, e.pc);
                chk("out_insn", out_insn, e.insn);
                chk("out_wen", out_wen, e.wen);
                chk("out_waddr", out_waddr, e.waddr);
                chk("out_wdata", out_wdata, e.wdata);
            end
            pops++;
            mocc--;
            if (chk_mismatch) mfail = 1;
        end
        n = int'(commit_valid[0]) + int'(commit_valid[1]) + int'(trap_valid);
        if (n > 0) begin
            if ((DEPTH - occ_old) >= COMMITS + 1) begin
                for (int i = 0; i < COMMITS; i++) begin
                    if (commit_valid[i]) begin
                        e.kind  = 1'b0;
                        e.pc    = commit_pc[i*XLEN +: XLEN];
                        e.insn  = commit_insn[i*32 +: 32];
                        e.waddr = commit_waddr[i*5 +: 5];
                        e.wen   = commit_wen[i] && (e.waddr != 5'd0);
                        e.wdata = commit_wdata[i*XLEN +: XLEN];
                        sb.push_back(e);
                    end
                end
                if (trap_valid) begin
                    e.kind = 1'b1; e.pc = '0; e.insn = '0; e.wen = 1'b0;
                    e.waddr = '0; e.wdata = trap_cause;
                    sb.push_back(e);
                end
                mocc += n;
            end else begin
                movf = 1;
            end
        end
        @(posedge clock); #1;
        chk("occupancy", occupancy, mocc);
        chk("overflow", overflow, movf);
        chk("fail", fail, mfail);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && mocc > 0; k++) step();
        chk("drain_occ", occupancy, 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    vec_t tbl[13];

    initial begin
        // Safety net in case the run ever stalls.
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'b11, 64'h80000000, 64'h80000004, 1'b1, 5'd3, 64'h1234, 1'b0, 64'h0, 2};
        tbl[1]  = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 1};
        tbl[2]  = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 0};
        tbl[3]  = '{2'b10, 64'h0, 64'h80000010, 1'b0, 5'd0, 64'h0, 1'b1, 64'h2, 2};
        tbl[4]  = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 1};
        tbl[5]  = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 0};
        tbl[6]  = '{2'b01, 64'h80000020, 64'h0, 1'b1, 5'd0, 64'hdead, 1'b0, 64'h0, 1};
        tbl[7]  = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 0};
        tbl[8]  = '{2'b11, 64'h80000030, 64'h80000034, 1'b0, 5'd7, 64'h77, 1'b1, 64'h8, 3};
        tbl[9]  = '{2'b01, 64'h80000038, 64'h0, 1'b1, 5'd9, 64'h99, 1'b0, 64'h0, 3};
        tbl[10] = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 2};
        tbl[11] = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 1};
        tbl[12] = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 0};

        reset = 1'b0; out_ready = 1'b0; chk_mismatch = 1'b0;
        idle();
        step(); step();
        reset = 1'b1;
        chk("rst_occ", occupancy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fail", fail, 0);
        chk("rst_overflow", overflow, 0);

        // Vector table: in-order, sparse+trap, x0 write suppression, push with pop.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].wen0, tbl[i].wa0,
                  tbl[i].wd0, tbl[i].trap, tbl[i].cause);
            step();
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
            if (i == 0) chk("first_pc", out_pc, 64'h80000000);
            if (i == 6) chk("x0_wen", out_wen, 0);
        end
        idle();

        // Backpressure: 8 full-lane cycles with the checker stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 64'h80001000 + 64'(8*k), 64'h80001004 + 64'(8*k),
                  1'b1, 5'(k + 1), 64'(k), 1'b0, 64'h0);
            step();
            if (k == 6) begin
                chk("bp_occ14", occupancy, 14);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_no_ovf_yet", overflow, 0);
            end
        end
        chk("bp_overflow", overflow, 1);
        chk("bp_occ_hold", occupancy, 14);
        idle();
        drain();
        chk("ovf_sticky", overflow, 1);

        // Mismatch on the third accepted event halts the stream.
        out_ready = 1'b0;
        drive(2'b11, 64'h80002000, 64'h80002004, 1'b1, 5'd1, 64'h10, 1'b0, 64'h0); step();
        drive(2'b11, 64'h80002008, 64'h8000200c, 1'b1, 5'd2, 64'h20, 1'b0, 64'h0); step();
        drive(2'b01, 64'h80002010, 64'h0, 1'b1, 5'd3, 64'h30, 1'b0, 64'h0); step();
        idle();
        out_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 10 && !mfail; k++) begin
            chk_mismatch = (pops == 2);
            step();
        end
        chk_mismatch = 1'b0;
        chk("mm_fail", fail, 1);
        chk("mm_out_valid", out_valid, 0);
        chk("mm_occ", occupancy, 2);
        chk("mm_pops", pops, 3);
        chk_mismatch = 1'b1;
        step(); step();
        chk_mismatch = 1'b0;
        drive(2'b11, 64'h80002020, 64'h80002024, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0); step();
        drive(2'b01, 64'h80002028, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0); step();
        idle();
        chk("halt_push_occ", occupancy, 5);

        // Reset with 5 buffered events and both flags set.
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst2_occ", occupancy, 0);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_fail", fail, 0);
        chk("rst2_overflow", overflow, 0);
        chk("rst2_in_ready", in_ready, 1);

        // Boundary: occupancy 13 still accepts a full cycle alongside a pop.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 64'h80003000 + 64'(8*k), 64'h80003004 + 64'(8*k),
                  1'b1, 5'd4, 64'(k), 1'b0, 64'h0);
            step();
        end
        drive(2'b01, 64'h80003100, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0); step();
        chk("full_occ13", occupancy, 13);
        out_ready = 1'b1;
        drive(2'b11, 64'h80003200, 64'h80003204, 1'b1, 5'd6, 64'h66, 1'b1, 64'hb);
        step();
        chk("full_occ15", occupancy, 15);
        chk("full_no_ovf", overflow, 0);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
